// File: rtl/ucsbece154a_mem_pkg.sv
// Shared definitions for the wait-state memory: FSM state encoding and
// helpers that size the word index and byte-offset fields.
package ucsbece154a_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    // A one-word array would need a zero-width index; keep at least one bit.
    function automatic int idx_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    function automatic int lsb_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ucsbece154a_mem_wait_if.sv
// Request/response bundle between a requester and the wait-state memory.
interface ucsbece154a_mem_wait_if #(
    parameter int DATA_W = 32
);
    import ucsbece154a_mem_pkg::*;

    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] a_i;
    logic [DATA_W-1:0] wd_i;
    logic              ready_o;
    logic              done_o;
    logic [DATA_W-1:0] rd_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output req_i, we_i, a_i, wd_i,
        input  ready_o, done_o, rd_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, a_i, wd_i,
        output ready_o, done_o, rd_o, busy_o, err_o
    );

endinterface

// File: rtl/ucsbece154a_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are never reset.
module ucsbece154a_mem_array
    import ucsbece154a_mem_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int DEPTH_WORDS = 64,
    localparam int IDX_W       = idx_w(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ucsbece154a_mem_wait.sv
// Single-port memory with a fixed number of wait states per access.
// Optional address range checking is enabled by defining MEM_WAIT_RANGE_CHK_EN.
module ucsbece154a_mem_wait
    import ucsbece154a_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ucsbece154a_mem_wait_if.slave bus
);

    localparam int IDX_W    = idx_w(DEPTH_WORDS);
    localparam int ADDR_LSB = lsb_w(DATA_W);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] WAIT = 2'(ST_WAIT);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic              ready;
    logic              accept;
    logic              oor_a;
    logic              commit;
    logic              done_rd;
    logic [DATA_W-1:0] arr_rd;
    logic [DATA_W-1:0] rd_now;
    logic              unused_addr;

    assign ready  = (state_q != WAIT);
    assign accept = bus.req_i && ready;

`ifdef MEM_WAIT_RANGE_CHK_EN
    assign oor_a = (bus.a_i >> (ADDR_LSB + IDX_W)) != '0;
`else
    assign oor_a = 1'b0;
`endif

    // Byte-offset bits and (without range checking) the high bits are don't-care.
    assign unused_addr = ^bus.a_i;

    // The write lands on the edge that leaves DONE; a reset on that edge aborts it.
    assign commit  = (state_q == DONE) && we_q && !oor_q && reset;
    assign done_rd = (state_q == DONE) && !we_q;
    assign rd_now  = oor_q ? '0 : arr_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        oor_d   = oor_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE, DONE: begin
                // Hold the value shown during a read completion for later cycles.
                if (done_rd) begin
                    rd_d = rd_now;
                end
                if (accept) begin
                    we_d    = bus.we_i;
                    oor_d   = oor_a;
                    idx_d   = bus.a_i[ADDR_LSB +: IDX_W];
                    wd_d    = bus.wd_i;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        wd_q  <= wd_d;
    end

    // Same-cycle read-after-commit works because the read port is combinational.
    ucsbece154a_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (commit),
        .waddr_i (idx_q),
        .wdata_i (wd_q),
        .raddr_i (idx_q),
        .rdata_o (arr_rd)
    );

    assign bus.ready_o = ready;
    assign bus.done_o  = (state_q == DONE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.rd_o    = done_rd ? rd_now : rd_q;
`ifdef MEM_WAIT_RANGE_CHK_EN
    assign bus.err_o   = (state_q == DONE) && oor_q;
`else
    assign bus.err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ucsbece154a_mem_wait.sv
// Bench for ucsbece154a_mem_wait: two instances (2 and 0 wait states),
// directed table, multi-cycle corner sequences and randomized transactions.
module tb_ucsbece154a_mem_wait;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset2, reset0;

    ucsbece154a_mem_wait_if #(.DATA_W(32)) bus2();
    ucsbece154a_mem_wait_if #(.DATA_W(32)) bus0();

    ucsbece154a_mem_wait #(.DATA_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2)
    );
    ucsbece154a_mem_wait #(.DATA_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset0), .bus(bus0)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model; unit 0 = 2 wait states, unit 1 = 0 wait states.
    logic [31:0] mdl_mem  [2][64];
    logic [31:0] mdl_last [2];

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int waits(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic bit mdl_oor(input logic [31:0] a);
`ifdef MEM_WAIT_RANGE_CHK_EN
        return (a >> 8) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mdl_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    task automatic mdl_expect(input int u, input logic we, input logic [31:0] a,
                              output logic [31:0] erd, output logic eerr);
        eerr = mdl_oor(a);
        if (we) erd = mdl_last[u];
        else    erd = mdl_oor(a) ? 32'h0 : mdl_mem[u][mdl_idx(a)];
    endtask

    task automatic mdl_commit(input int u, input logic we, input logic [31:0] a,
                              input logic [31:0] wd);
        if (we && !mdl_oor(a)) mdl_mem[u][mdl_idx(a)] = wd;
        if (!we) mdl_last[u] = mdl_oor(a) ? 32'h0 : mdl_mem[u][mdl_idx(a)];
    endtask

    task automatic drive(input int u, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (u == 0) begin
            bus2.req_i = req; bus2.we_i = we; bus2.a_i = a; bus2.wd_i = wd;
        end else begin
            bus0.req_i = req; bus0.we_i = we; bus0.a_i = a; bus0.wd_i = wd;
        end
    endtask

    function automatic logic get_ready(input int u);
        return (u == 0) ? bus2.ready_o : bus0.ready_o;
    endfunction
    function automatic logic get_done(input int u);
        return (u == 0) ? bus2.done_o : bus0.done_o;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 0) ? bus2.busy_o : bus0.busy_o;
    endfunction
    function automatic logic get_err(input int u);
        return (u == 0) ? bus2.err_o : bus0.err_o;
    endfunction
    function automatic logic [31:0] get_rd(input int u);
        return (u == 0) ? bus2.rd_o : bus0.rd_o;
    endfunction

    // Called just after a rising edge; returns in the completion cycle.
    task automatic txn(input int u, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic err);
        int n;
        drive(u, 1'b1, we, a, wd);
        n = 0;
        while (!get_ready(u) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!get_done(u) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = get_rd(u);
        err = get_err(u);
    endtask

    task automatic txn_model(input int u, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input string nm);
        logic [31:0] erd, rd;
        logic        eerr, err;
        int          lat;
        mdl_expect(u, we, a, erd, eerr);
        txn(u, we, a, wd, lat, rd, err);
        chk({nm, "_lat"}, 64'(lat), 64'(waits(u) + 1));
        chk({nm, "_rd"}, {32'h0, rd}, {32'h0, erd});
        chk({nm, "_err"}, {63'h0, err}, {63'h0, eerr});
        mdl_commit(u, we, a, wd);
    endtask

    task automatic idle_cycle(input int u);
        drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a;
        logic        err, we;
        int          lat, ndone, u;
        bit          back2back;

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h0000_0A0A, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0008, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_000A, 32'h0000_0000, 32'h1111_2222, 1'b0};
`ifdef MEM_WAIT_RANGE_CHK_EN
        tbl[5] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h1111_2222, 1'b1};
        tbl[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0A0A, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0000_0000, 1'b1};
`else
        tbl[5] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h1111_2222, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
`endif

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset2 = 1'b0;
        reset0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_ready", k), 64'(get_ready(k)), 64'd1);
            chk($sformatf("rst%0d_done", k), 64'(get_done(k)), 64'd0);
            chk($sformatf("rst%0d_busy", k), 64'(get_busy(k)), 64'd0);
            chk($sformatf("rst%0d_err", k), 64'(get_err(k)), 64'd0);
            chk($sformatf("rst%0d_rd", k), 64'(get_rd(k)), 64'd0);
        end
        reset2 = 1'b1;
        reset0 = 1'b1;
        @(posedge clk); #1;
        mdl_last[0] = 32'h0;
        mdl_last[1] = 32'h0;

        // Give every word a known value in both instances.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                txn_model(k, 1'b1, 32'(i) << 2, $urandom, "fill");
            end
            idle_cycle(k);
        end

        // Directed vectors on the 2-wait-state instance.
        for (int i = 0; i < 8; i++) begin
            txn(0, tbl[i].we, tbl[i].a, tbl[i].wd, lat, rd, err);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd3);
            chk($sformatf("tbl%0d_rd", i), {32'h0, rd}, {32'h0, tbl[i].exp_rd});
            chk($sformatf("tbl%0d_err", i), {63'h0, err}, {63'h0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_busy", i), 64'(get_busy(0)), 64'd1);
            mdl_commit(0, tbl[i].we, tbl[i].a, tbl[i].wd);
        end
        idle_cycle(0);
        chk("done_pulse_one_cycle", 64'(get_done(0)), 64'd0);

        // Zero-wait back-to-back read, write, read of word 3.
        txn_model(1, 1'b1, 32'h0000_000C, 32'h0000_0055, "b2b_pre");
        idle_cycle(1);
        drive(1, 1'b1, 1'b0, 32'h0000_000C, 32'h0);
        @(posedge clk); #1;
        chk("b2b_r1_done", 64'(get_done(1)), 64'd1);
        chk("b2b_r1_rd", 64'(get_rd(1)), 64'h55);
        drive(1, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_A5A5);
        @(posedge clk); #1;
        chk("b2b_w_done", 64'(get_done(1)), 64'd1);
        chk("b2b_w_rd_hold", 64'(get_rd(1)), 64'h55);
        drive(1, 1'b1, 1'b0, 32'h0000_000C, 32'h0);
        @(posedge clk); #1;
        chk("b2b_r2_done", 64'(get_done(1)), 64'd1);
        chk("b2b_r2_rd", 64'(get_rd(1)), 64'hA5A5);
        idle_cycle(1);
        chk("b2b_end_done", 64'(get_done(1)), 64'd0);
        chk("b2b_end_busy", 64'(get_busy(1)), 64'd0);
        chk("b2b_end_rd", 64'(get_rd(1)), 64'hA5A5);
        mdl_mem[1][3] = 32'h0000_A5A5;
        mdl_last[1]   = 32'h0000_A5A5;

        // Reset during the wait phase of a write to word 5.
        txn_model(0, 1'b1, 32'h0000_0014, 32'h0000_7777, "abort_pre");
        idle_cycle(0);
        drive(0, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_1234);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_wait_ready", 64'(get_ready(0)), 64'd0);
        chk("abort_wait_busy", 64'(get_busy(0)), 64'd1);
        reset2 = 1'b0;
        @(posedge clk); #1;
        reset2 = 1'b1;
        chk("abort_ready", 64'(get_ready(0)), 64'd1);
        chk("abort_busy", 64'(get_busy(0)), 64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (get_done(0)) ndone++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        mdl_last[0] = 32'h0;
        txn_model(0, 1'b0, 32'h0000_0014, 32'h0, "abort_read");
        idle_cycle(0);

        // Request held high: one completion per accept, each spaced WAIT+1 cycles.
        drive(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        ndone = 0;
        back2back = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (get_done(0)) begin
                if (ndone > 0 && back2back) back2back = 1'b1;
                ndone++;
                chk("hold_rd", 64'(get_rd(0)), 64'(mdl_mem[0][1]));
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hold_done_count", 64'(ndone), 64'd3);
        mdl_last[0] = mdl_mem[0][1];
        @(posedge clk); #1;
        chk("hold_idle_done", 64'(get_done(0)), 64'd0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            u  = i % 2;
            we = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) a = $urandom | 32'h0000_0100;
            else a = (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
            if ($urandom_range(1) == 1) idle_cycle(u);
            txn_model(u, we, a, $urandom, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucsbece154a_mem_wait.md
UCSBECE154A_MEM_WAIT -- requirements
Module: ucsbece154a_mem_wait

Interface
REQ-001 Parameters, one per line:
- DATA_W, 32: data word width in bits (8, 16, 32 or 64).
- DEPTH_WORDS, 64: number of words stored (power of two, >= 2).
- WAIT_CYCLES, 2: extra wait states per access (0..15).
REQ-002 Ports, one per line:
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- req_i, input, 1: access request.
- we_i, input, 1: 1 = write, 0 = read; sampled on accept.
- a_i, input, 32: byte address; sampled on accept.
- wd_i, input, DATA_W: write data; sampled on accept.
- ready_o, output, 1: the block accepts a request this cycle.
- done_o, output, 1: one-cycle pulse marking completion of the accepted access.
- rd_o, output, DATA_W: read data.
- busy_o, output, 1: a transaction is in flight.
- err_o, output, 1: the completing access was out of range.

Function
REQ-003 The block SHALL use a three-state FSM (IDLE, WAIT, DONE).
REQ-004 ready_o SHALL be 1 in IDLE and in DONE, and 0 in WAIT.
REQ-005 Accept SHALL occur on any cycle with req_i=1 and ready_o=1; a_i, we_i and wd_i SHALL be registered on that edge.
REQ-006 On accept, the FSM SHALL go to WAIT with a counter loaded to WAIT_CYCLES-1, or straight to DONE when WAIT_CYCLES=0.
REQ-007 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to DONE on the cycle the counter reads 0.
REQ-008 done_o SHALL be 1 exactly while in DONE, which is WAIT_CYCLES+1 cycles after the accept edge.
REQ-009 From DONE, the FSM SHALL go to WAIT/DONE on a new accept (back-to-back), otherwise to IDLE.
REQ-010 busy_o SHALL be 1 in WAIT and DONE.
REQ-011 Word index SHALL be a[ADDR_LSB +: log2(DEPTH_WORDS)], where ADDR_LSB = log2(DATA_W/8); byte-offset bits SHALL be ignored.
REQ-012 A write SHALL be committed to the array on the edge leaving DONE, never earlier.
REQ-013 For reads, rd_o SHALL present the array word at the registered index while done_o=1.
REQ-014 rd_o SHALL hold its value until the next read completes; a completing write SHALL NOT change rd_o.
REQ-015 A read of the address written by the immediately preceding back-to-back write SHALL return the new data.
REQ-016 req_i while ready_o=0 SHALL be ignored; no queuing, and the requester holds req_i.

Reset
REQ-017 When reset=0 at a clock edge, the block SHALL set: FSM=IDLE, counter=0, ready_o=1, done_o=0, busy_o=0, err_o=0, rd_o=0.
REQ-018 Reset mid-transaction SHALL abort the access; a pending write SHALL NOT be committed.
REQ-019 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro MEM_WAIT_RANGE_CHK_EN, when defined, SHALL flag any a_i[31:ADDR_LSB] >= DEPTH_WORDS as out of range.
REQ-021 With MEM_WAIT_RANGE_CHK_EN defined, an out-of-range access SHALL pulse err_o with done_o, suppress any write, and set rd_o=0 for reads.
REQ-022 With MEM_WAIT_RANGE_CHK_EN undefined, the index SHALL truncate (address wrap) and err_o SHALL be tied 0.

Structure
REQ-023 Package ucsbece154a_mem_pkg SHALL hold the FSM state enum and the clog2-based index/offset width constants.
REQ-024 Storage SHALL be a sub-module ucsbece154a_mem_array: one synchronous write port, one combinational read port, parametrised on DATA_W and DEPTH_WORDS.

Verification
REQ-025 Bench SHALL cover, with WAIT_CYCLES=2, write 0x0000_0004 <- 0xDEADBEEF, then read 0x0000_0004 -> done_o 3 cycles after each accept and rd_o=0xDEADBEEF.
REQ-026 Bench SHALL cover, with WAIT_CYCLES=0, back-to-back read, write, read on consecutive cycles -> done_o every cycle, and the second read returns the written data.
REQ-027 Bench SHALL cover reset=0 in the WAIT cycle of a write of 0x1234 to word 5 -> ready_o=1, done_o never pulses, and a later read of word 5 returns the old value.
REQ-028 Bench SHALL cover, with DEPTH_WORDS=64, a write to byte address 0x100 -> with the macro, err_o=1 and word 0 unchanged; without it, word 0 = written data.
REQ-029 Bench SHALL cover req_i held through WAIT -> exactly one access is performed per accept.
